// File: rtl/glitch_sequencer.sv
// glitch_sequencer: multi-slot trigger/delay/pulse glitch generator; define GLITCH_SEQUENCER_TIMEOUT_EN to add an ARMED-state timeout
module glitch_sequencer #(
    parameter int CNT_WIDTH    = 32,
    parameter int NUM_GLITCHES = 4,
    parameter int IDX_WIDTH    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_field,
    input  logic [IDX_WIDTH-1:0] cfg_idx,
    input  logic [CNT_WIDTH-1:0] cfg_data,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 trig_rising,
    input  logic                 trigger_in,
    output logic                 glitch_out,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state,
    output logic [IDX_WIDTH-1:0] glitch_index
`ifdef GLITCH_SEQUENCER_TIMEOUT_EN
    ,
    input  logic [CNT_WIDTH-1:0] timeout_len,
    output logic                 timed_out
`endif
);
    localparam int NW = $clog2(NUM_GLITCHES + 1);
    localparam logic [CNT_WIDTH-1:0] ONE = 1;
    localparam logic [CNT_WIDTH-1:0] MAX_NUM = CNT_WIDTH'(NUM_GLITCHES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        DELAY = 3'd2,
        PULSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 cur, nxt;
    logic [CNT_WIDTH-1:0]   delays [NUM_GLITCHES];
    logic [CNT_WIDTH-1:0]   widths [NUM_GLITCHES];
    logic [NW-1:0]          num_glitches;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
    logic [IDX_WIDTH-1:0]   idx, idx_nxt, sel;
    logic [IDX_WIDTH:0]     start;
    logic                   found, begin_slot;
    logic                   sync1, sync2, prev, edge_det;
`ifdef GLITCH_SEQUENCER_TIMEOUT_EN
    logic [CNT_WIDTH-1:0]   tcnt, tcnt_nxt;
    logic                   to_nxt;
`endif

    assign edge_det     = (sync2 != prev) && (sync2 == trig_rising);
    assign state        = cur;
    assign busy         = cur != IDLE;
    assign done         = cur == DONE;
    assign glitch_index = (cur == DELAY || cur == PULSE) ? idx : '0;

    // trigger synchroniser and previous-value flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= trigger_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // slot and count configuration, writable only while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_GLITCHES; k++) begin
                delays[k] <= '0;
                widths[k] <= '0;
            end
            num_glitches <= NW'(1);
        end else if (cfg_we && cur == IDLE) begin
            if (cfg_field == 2'd0 && int'(cfg_idx) < NUM_GLITCHES) delays[cfg_idx] <= cfg_data;
            if (cfg_field == 2'd1 && int'(cfg_idx) < NUM_GLITCHES) widths[cfg_idx] <= cfg_data;
            if (cfg_field == 2'd2) num_glitches <= (cfg_data > MAX_NUM) ? NW'(NUM_GLITCHES) : cfg_data[NW-1:0];
        end
    end

    // find the first slot at or after the starting slot that has a nonzero width
    always_comb begin
        start = (cur == PULSE) ? (IDX_WIDTH+1)'(idx) + (IDX_WIDTH+1)'(1) : '0;
        found = 1'b0;
        sel   = '0;
        for (int k = NUM_GLITCHES - 1; k >= 0; k--)
            if (k >= int'(start) && k < int'(num_glitches) && widths[k] != '0) begin
                found = 1'b1;
                sel   = IDX_WIDTH'(k);
            end
    end

    // next-state, counter and slot-index logic; abort overrides everything
    always_comb begin
        nxt        = cur;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        begin_slot = 1'b0;
`ifdef GLITCH_SEQUENCER_TIMEOUT_EN
        tcnt_nxt   = '0;
        to_nxt     = 1'b0;
`endif
        case (cur)
            IDLE:  if (arm && num_glitches != '0) nxt = ARMED;
`ifdef GLITCH_SEQUENCER_TIMEOUT_EN
            ARMED: if (edge_det) begin_slot = 1'b1;
                   else if (timeout_len != '0 && tcnt == timeout_len - ONE) begin
                       nxt    = IDLE;
                       to_nxt = 1'b1;
                   end else tcnt_nxt = tcnt + ONE;
`else
            ARMED: if (edge_det) begin_slot = 1'b1;
`endif
            DELAY: if (cnt == '0) begin
                       nxt     = PULSE;
                       cnt_nxt = widths[idx] - ONE;
                   end else cnt_nxt = cnt - ONE;
            PULSE: if (cnt == '0) begin_slot = 1'b1;
                   else cnt_nxt = cnt - ONE;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (begin_slot) begin
            nxt     = !found ? DONE : (delays[sel] != '0 ? DELAY : PULSE);
            idx_nxt = found ? sel : '0;
            cnt_nxt = !found ? '0 : (delays[sel] != '0 ? delays[sel] - ONE : widths[sel] - ONE);
        end
        if (abort) begin
            nxt     = IDLE;
            cnt_nxt = '0;
            idx_nxt = '0;
`ifdef GLITCH_SEQUENCER_TIMEOUT_EN
            tcnt_nxt = '0;
            to_nxt   = 1'b0;
`endif
        end
    end

    // state register; glitch_out comes straight from a flop so it cannot glitch
    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            glitch_out <= 1'b0;
`ifdef GLITCH_SEQUENCER_TIMEOUT_EN
            tcnt       <= '0;
            timed_out  <= 1'b0;
`endif
        end else begin
            cur        <= nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            glitch_out <= nxt == PULSE;
`ifdef GLITCH_SEQUENCER_TIMEOUT_EN
            tcnt       <= tcnt_nxt;
            timed_out  <= to_nxt;
`endif
        end
    end
endmodule
